// File: rtl/sim_host_port_if.sv
// Bus, console-stream and halt signals between the core-side interconnect
// and the simulation host port.
interface sim_host_port_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            halted;
  logic [XLEN-1:0] exit_code;

  // Handshakes: a request transfers on a cycle where req_valid && req_ready;
  // a console byte transfers on a cycle where tx_valid && tx_ready. A producer
  // holds valid and its payload stable until the transfer happens.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, tx_ready,
    output req_ready, resp_valid, resp_rdata, tx_valid, tx_data, halted, exit_code
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, tx_ready,
    input  req_ready, resp_valid, resp_rdata, tx_valid, tx_data, halted, exit_code
  );
endinterface

// File: rtl/sim_host_port.sv
// Memory-mapped host port: console byte FIFO drained toward the host,
// a STATUS register, and a sticky EXIT code that ends the simulation.
module sim_host_port #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  sim_host_port_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_EXIT   = 2'd2;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
  logic             halted_q, halted_d;
  logic [XLEN-1:0]  exit_code_q, exit_code_d;

  logic [1:0]       sel;
  logic             full, empty;
  logic             req_ready, accept, enq, deq;
  logic [XLEN-1:0]  status, load_data;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus.req_addr[XLEN-1:4], bus.req_addr[1:0]};

  // Full is taken from registered count only, so a same-cycle dequeue never
  // lets a store into a full FIFO.
  always_comb begin
    sel       = bus.req_addr[3:2];
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    empty     = (count_q == '0);
    req_ready = !(bus.req_we && (sel == ADDR_TXDATA) && full);
    accept    = bus.req_valid && req_ready;
    enq       = accept && bus.req_we && (sel == ADDR_TXDATA);
    deq       = !empty && bus.tx_ready;

    status       = '0;
    status[15:8] = 8'(count_q);
    status[1]    = full;
    status[0]    = empty;

    case (sel)
      ADDR_STATUS: load_data = status;
      ADDR_EXIT:   load_data = exit_code_q;
      default:     load_data = '0;
    endcase
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    resp_valid_d = accept;
    resp_rdata_d = (accept && !bus.req_we) ? load_data : '0;
    halted_d     = halted_q;
    exit_code_d  = exit_code_q;

    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (accept && bus.req_we && (sel == ADDR_EXIT) && !halted_q) begin
      halted_d    = 1'b1;
      exit_code_d = bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      halted_q     <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      halted_q     <= halted_d;
      exit_code_q  <= exit_code_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= bus.req_wdata[7:0];
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.tx_valid   = !empty;
  assign bus.tx_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.halted     = halted_q;
  assign bus.exit_code  = exit_code_q;
endmodule
